io_stall_sequencer: RTL and testbench
=====================================

Name: io_stall_sequencer

Overview:
Sequences the processor's blocking I/O instructions and OS-request entry. Runs on fast_clock beside the slow_clock datapath. Drives the datapath `enable` (stall) line:
- Input instruction: holds the core until the operator confirms switch data.
- Output instruction: holds the core until the operator presses continue.
- OS request button: latched and presented to control as a pending request.

Parameters:
IO_WIDTH, 16, width of switch input and LED/display data
WORD_SIZE, 32, width of captured input word handed to the datapath
BLINK_CYCLES, 8_000_000, fast_clock cycles per half-period of the wait indicator
BLINK_WIDTH, 24, counter width; must satisfy 2^BLINK_WIDTH > BLINK_CYCLES

Ports:
fast_clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low; 0 = reset
slow_clock  in  1  datapath clock, sampled as data (edge-detected)
is_input  in  1  decoded input instruction from control
is_output  in  1  decoded output instruction from control
is_os  in  1  control is executing in OS mode
confirmation  in  1  debounced confirm button, level
continue_debounced  in  1  debounced continue button, level
user_request  in  1  debounced OS request button, level
sw  in  IO_WIDTH  switch data
out_data  in  IO_WIDTH  register value to display (low bits of MemOut)
enable  out  1  datapath enable; 0 = stall
in_data  out  WORD_SIZE  captured switch word, zero-extended
display_data  out  IO_WIDTH  latched output value
os_request  out  1  pending OS request to control
waiting  out  1  blink indicator while stalled for operator

Behaviour:
- Reset values (reset=0, async):
  - state RUN, enable=1, in_data=0, display_data=0, os_request=0, waiting=0.
  - Blink counter 0; all edge-detector history registers 0.
- Edge detection:
  - Rising edges of confirmation, continue_debounced, user_request and slow_clock are each prev=0 & cur=1, one fast_clock pulse.
  - Inputs are already synchronous to fast_clock.
- States: RUN, IN_WAIT, IN_RELEASE, OUT_WAIT, COMMIT.
- RUN:
  - enable=1.
  - is_input & ~is_output → IN_WAIT; enable registered 0 next cycle.
  - is_output & ~is_input → display_data<=out_data, → OUT_WAIT, enable 0 next cycle.
  - Both high or both low → stay RUN (no-op).
- IN_WAIT:
  - enable=0.
  - Confirmation rising edge → in_data<={zeros, sw}, → IN_RELEASE.
  - A level already high at entry does not count; a fresh edge is required.
- IN_RELEASE: enable=0; confirmation low → COMMIT.
- OUT_WAIT: enable=0; continue rising edge → COMMIT. display_data holds until the next output instruction.
- COMMIT:
  - enable=1; is_input/is_output are ignored.
  - slow_clock rising edge → RUN.
  - This guarantees the I/O instruction retires exactly once and is not re-triggered.
- Latency: enable falls exactly 1 fast_clock after is_input/is_output are sampled. System requirement: slow_clock period ≥ 4 fast_clock cycles.
- waiting:
  - In IN_WAIT/IN_RELEASE/OUT_WAIT, the counter increments; at BLINK_CYCLES-1 it wraps to 0 and toggles waiting.
  - On leaving these states, counter=0 and waiting=0 in the same cycle.
- OS request:
  - user_request rising edge sets a sticky pending bit in any state.
  - os_request = pending & (state==RUN) & ~is_os, registered.
  - Pending clears on the cycle is_os is sampled 1.
  - A request edge while already pending is absorbed (no count).
  - If a request edge and an I/O start occur in the same cycle, I/O wins; the request stays pending and is presented after return to RUN.
- Reset mid-operation (any state): immediate return to reset values; pending request and captured data lost.

Decomposition:
- Shared package arm_io_pkg: state enumeration (3-bit encoding RUN=0, IN_WAIT=1, IN_RELEASE=2, OUT_WAIT=3, COMMIT=4) and default widths IO_WIDTH/WORD_SIZE.
- One sub-module: rise_detect (single-bit registered rising-edge detector, async active-low reset), instantiated four times.

Test Plan:
- Reset asserted mid-IN_WAIT with sw=16'hBEEF → enable=1, in_data=0, state RUN immediately, before any clock.
- is_input pulse, sw=16'h00A5, confirm press/release, one slow_clock edge:
  - enable=0 one cycle after is_input.
  - in_data=32'h000000A5.
  - enable=1 in COMMIT; RUN after the slow edge; is_input still high in COMMIT does not re-stall.
- confirmation already high when is_input arrives → stays IN_WAIT until confirmation drops and rises again.
- is_output with out_data=16'h1234 → display_data=16'h1234, enable=0 until continue edge; waiting toggles every BLINK_CYCLES (override BLINK_CYCLES=4: toggles at cycles 4, 8, ...).
- is_input=is_output=1 → no stall, enable stays 1, display_data/in_data unchanged.
- user_request edge in same cycle as is_output:
  - os_request=0 during OUT_WAIT.
  - os_request=1 after return to RUN.
  - os_request clears the cycle after is_os=1.
  - A second edge while pending yields a single request.

Source files
------------

// File: rtl/arm_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_io_pkg
//  Description : Shared state encoding and default widths for the blocking
//                I/O stall sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package arm_io_pkg;

    // Default data widths
    localparam int C_IO_WIDTH_DEF  = 16;
    localparam int C_WORD_SIZE_DEF = 32;

    // Sequencer state encoding (3-bit, fixed values)
    localparam logic [2:0] C_ST_RUN        = 3'd0;
    localparam logic [2:0] C_ST_IN_WAIT    = 3'd1;
    localparam logic [2:0] C_ST_IN_RELEASE = 3'd2;
    localparam logic [2:0] C_ST_OUT_WAIT   = 3'd3;
    localparam logic [2:0] C_ST_COMMIT     = 3'd4;

    // True while the core is parked waiting for the operator
    function automatic logic is_wait_state(input logic [2:0] s);
        return (s == C_ST_IN_WAIT) || (s == C_ST_IN_RELEASE) || (s == C_ST_OUT_WAIT);
    endfunction

endpackage : arm_io_pkg
`default_nettype wire

// File: rtl/io_stall_sequencer_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Single-bit rising-edge detector. The input is already
//                synchronous to clk; the pulse lasts exactly one clk cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic prev_q;
    logic prev_d;

    // History register tracks the previous sample of the input
    always_comb begin
        prev_d = i_d;
    end

    // History flop, cleared so a level high out of reset reads as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_rise = i_d & ~prev_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/io_stall_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : io_stall_sequencer
//  Description : Stalls the slow_clock datapath around blocking input/output
//                instructions until the operator responds, and latches the
//                OS request button into a pending request for control.
//  Revision    : 1.0  initial release
// ============================================================================
module io_stall_sequencer
    import arm_io_pkg::*;
#(
    parameter int IO_WIDTH     = C_IO_WIDTH_DEF,
    parameter int WORD_SIZE    = C_WORD_SIZE_DEF,
    parameter int BLINK_CYCLES = 8_000_000,
    parameter int BLINK_WIDTH  = 24
) (
    input  logic                 fast_clock,
    input  logic                 reset,
    input  logic                 slow_clock,
    input  logic                 is_input,
    input  logic                 is_output,
    input  logic                 is_os,
    input  logic                 confirmation,
    input  logic                 continue_debounced,
    input  logic                 user_request,
    input  logic [IO_WIDTH-1:0]  sw,
    input  logic [IO_WIDTH-1:0]  out_data,
    output logic                 enable,
    output logic [WORD_SIZE-1:0] in_data,
    output logic [IO_WIDTH-1:0]  display_data,
    output logic                 os_request,
    output logic                 waiting
);

    localparam logic [BLINK_WIDTH-1:0] C_BLINK_MAX = BLINK_WIDTH'(BLINK_CYCLES - 1);

    logic                   confirm_rise;
    logic                   continue_rise;
    logic                   request_rise;
    logic                   slow_rise;

    logic [2:0]             state_q,     state_d;
    logic                   enable_q,    enable_d;
    logic [WORD_SIZE-1:0]   in_data_q,   in_data_d;
    logic [IO_WIDTH-1:0]    display_q,   display_d;
    logic                   pending_q,   pending_d;
    logic                   os_req_q,    os_req_d;
    logic [BLINK_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
    logic                   waiting_q,   waiting_d;

    rise_detect u_rise_confirm  (.clk(fast_clock), .rst_n(reset), .i_d(confirmation),       .o_rise(confirm_rise));
    rise_detect u_rise_continue (.clk(fast_clock), .rst_n(reset), .i_d(continue_debounced), .o_rise(continue_rise));
    rise_detect u_rise_request  (.clk(fast_clock), .rst_n(reset), .i_d(user_request),       .o_rise(request_rise));
    rise_detect u_rise_slow     (.clk(fast_clock), .rst_n(reset), .i_d(slow_clock),         .o_rise(slow_rise));

    // Sequencer next state, captured input word and latched display value
    always_comb begin
        state_d   = state_q;
        in_data_d = in_data_q;
        display_d = display_q;
        case (state_q)
            C_ST_RUN: begin
                if (is_input && !is_output) begin
                    state_d = C_ST_IN_WAIT;
                end else if (is_output && !is_input) begin
                    display_d = out_data;
                    state_d   = C_ST_OUT_WAIT;
                end
            end
            C_ST_IN_WAIT: begin
                // Only a fresh press counts; a level held since entry is ignored
                if (confirm_rise) begin
                    in_data_d = {{(WORD_SIZE - IO_WIDTH){1'b0}}, sw};
                    state_d   = C_ST_IN_RELEASE;
                end
            end
            C_ST_IN_RELEASE: begin
                if (!confirmation) begin
                    state_d = C_ST_COMMIT;
                end
            end
            C_ST_OUT_WAIT: begin
                if (continue_rise) begin
                    state_d = C_ST_COMMIT;
                end
            end
            C_ST_COMMIT: begin
                // Run until the datapath takes one slow edge so the I/O
                // instruction retires once and cannot re-trigger the stall
                if (slow_rise) begin
                    state_d = C_ST_RUN;
                end
            end
            default: begin
                state_d = C_ST_RUN;
            end
        endcase
    end

    // Enable is registered from the next state so it falls one cycle after is_input/is_output
    always_comb begin
        enable_d = (state_d == C_ST_RUN) || (state_d == C_ST_COMMIT);
    end

    // Sticky OS request; only presented while running, so an I/O start wins a tie
    always_comb begin
        pending_d = pending_q | request_rise;
        if (is_os) begin
            pending_d = 1'b0;
        end
        os_req_d = pending_d && (state_d == C_ST_RUN) && !is_os;
    end

    // Wait-indicator blink counter, cleared the same cycle the wait ends
    always_comb begin
        blink_cnt_d = '0;
        waiting_d   = 1'b0;
        if (is_wait_state(state_q) && is_wait_state(state_d)) begin
            if (blink_cnt_q == C_BLINK_MAX) begin
                blink_cnt_d = '0;
                waiting_d   = ~waiting_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_WIDTH'(1);
                waiting_d   = waiting_q;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge fast_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= C_ST_RUN;
            enable_q    <= 1'b1;
            in_data_q   <= '0;
            display_q   <= '0;
            pending_q   <= 1'b0;
            os_req_q    <= 1'b0;
            blink_cnt_q <= '0;
            waiting_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            in_data_q   <= in_data_d;
            display_q   <= display_d;
            pending_q   <= pending_d;
            os_req_q    <= os_req_d;
            blink_cnt_q <= blink_cnt_d;
            waiting_q   <= waiting_d;
        end
    end

    assign enable       = enable_q;
    assign in_data      = in_data_q;
    assign display_data = display_q;
    assign os_request   = os_req_q;
    assign waiting      = waiting_q;

endmodule : io_stall_sequencer
`default_nettype wire

// File: tb/tb_io_stall_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_stall_sequencer
//  Description : Self-checking bench for io_stall_sequencer with a shortened
//                blink period; expected words are queued as stimulus is
//                driven and popped when the DUT presents them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_stall_sequencer;

    logic        fast_clock;
    logic        reset;
    logic        slow_clock;
    logic        is_input;
    logic        is_output;
    logic        is_os;
    logic        confirmation;
    logic        continue_debounced;
    logic        user_request;
    logic [15:0] sw;
    logic [15:0] out_data;
    logic        enable;
    logic [31:0] in_data;
    logic [15:0] display_data;
    logic        os_request;
    logic        waiting;

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;

    io_stall_sequencer #(
        .IO_WIDTH    (16),
        .WORD_SIZE   (32),
        .BLINK_CYCLES(4),
        .BLINK_WIDTH (3)
    ) dut (
        .fast_clock        (fast_clock),
        .reset             (reset),
        .slow_clock        (slow_clock),
        .is_input          (is_input),
        .is_output         (is_output),
        .is_os             (is_os),
        .confirmation      (confirmation),
        .continue_debounced(continue_debounced),
        .user_request      (user_request),
        .sw                (sw),
        .out_data          (out_data),
        .enable            (enable),
        .in_data           (in_data),
        .display_data      (display_data),
        .os_request        (os_request),
        .waiting           (waiting)
    );

    initial fast_clock = 1'b0;
    always #5 fast_clock = ~fast_clock;

    // Inputs change and outputs are sampled on the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge fast_clock);
    endtask

    task automatic slow_pulse();
        slow_clock = 1'b1;
        cyc(2);
        slow_clock = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        reset = 1'b0; slow_clock = 1'b0; is_input = 1'b0; is_output = 1'b0;
        is_os = 1'b0; confirmation = 1'b0; continue_debounced = 1'b0;
        user_request = 1'b0; sw = '0; out_data = '0;
        cyc(3);
        tests_run++;
        if ({enable, in_data, display_data, os_request, waiting} !== {1'b1, 32'h0, 16'h0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_values: got en=%b in=%h disp=%h os=%b wait=%b required 1/0/0/0/0",
                     enable, in_data, display_data, os_request, waiting);
        end
        reset = 1'b1;
        cyc(2);
        // Park in IN_WAIT long enough for the indicator to turn on, with a pending request
        is_input = 1'b1; sw = 16'hBEEF;
        cyc(1);
        is_input = 1'b0; user_request = 1'b1;
        cyc(5);
        tests_run++;
        if (enable !== 1'b0 || waiting !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre_in_wait: got en=%b wait=%b required en=0 wait=1", enable, waiting);
        end
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if (enable !== 1'b1 || in_data !== 32'h0 || waiting !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got en=%b in=%h wait=%b required en=1 in=0 wait=0",
                     enable, in_data, waiting);
        end
        user_request = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(3);
        tests_run++;
        if (os_request !== 1'b0 || enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pending_lost: got os=%b en=%b required os=0 en=1", os_request, enable);
        end
    endtask

    task automatic test_input();
        is_input = 1'b1; sw = 16'h00A5;
        cyc(1);
        tests_run++;
        if (enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL input_stall_latency: got en=%b required 0", enable);
        end
        confirmation = 1'b1;
        exp_q.push_back(32'h0000_00A5);
        cyc(1);
        confirmation = 1'b0;
        cyc(1);
        // Entered COMMIT: datapath runs and the captured word is presented
        exp_word = exp_q.pop_front();
        tests_run++;
        if (enable !== 1'b1 || in_data !== exp_word) begin
            tests_failed++;
            $display("FAIL input_commit: got en=%b in=%h required en=1 in=%h", enable, in_data, exp_word);
        end
        cyc(3);
        tests_run++;
        if (enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL input_no_retrigger: got en=%b required 1", enable);
        end
        is_input = 1'b0;
        slow_pulse();
        tests_run++;
        if (enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL input_back_to_run: got en=%b required 1", enable);
        end
    endtask

    task automatic test_confirm_held();
        confirmation = 1'b1;
        cyc(2);
        is_input = 1'b1; sw = 16'h005A;
        cyc(1);
        is_input = 1'b0;
        cyc(4);
        tests_run++;
        if (enable !== 1'b0 || in_data !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL held_level_ignored: got en=%b in=%h required en=0 in=000000a5", enable, in_data);
        end
        confirmation = 1'b0;
        cyc(2);
        tests_run++;
        if (enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_still_waiting: got en=%b required 0", enable);
        end
        confirmation = 1'b1;
        exp_q.push_back(32'h0000_005A);
        cyc(1);
        confirmation = 1'b0;
        cyc(1);
        exp_word = exp_q.pop_front();
        tests_run++;
        if (enable !== 1'b1 || in_data !== exp_word) begin
            tests_failed++;
            $display("FAIL held_fresh_edge: got en=%b in=%h required en=1 in=%h", enable, in_data, exp_word);
        end
        slow_pulse();
    endtask

    task automatic test_output();
        out_data = 16'h1234; is_output = 1'b1;
        exp_q.push_back(32'h0000_1234);
        cyc(1);
        is_output = 1'b0; out_data = 16'hFFFF;
        exp_word = exp_q.pop_front();
        tests_run++;
        if (enable !== 1'b0 || display_data !== exp_word[15:0] || waiting !== 1'b0) begin
            tests_failed++;
            $display("FAIL output_latch: got en=%b disp=%h wait=%b required en=0 disp=%h wait=0",
                     enable, display_data, waiting, exp_word[15:0]);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            tests_run++;
            if (waiting !== (((k / 4) % 2) == 1)) begin
                tests_failed++;
                $display("FAIL output_blink_%0d: got wait=%b required %b", k, waiting, ((k / 4) % 2) == 1);
            end
        end
        continue_debounced = 1'b1;
        cyc(1);
        tests_run++;
        if (enable !== 1'b1 || waiting !== 1'b0 || display_data !== 16'h1234) begin
            tests_failed++;
            $display("FAIL output_continue: got en=%b wait=%b disp=%h required en=1 wait=0 disp=1234",
                     enable, waiting, display_data);
        end
        continue_debounced = 1'b0;
        slow_pulse();
    endtask

    task automatic test_both();
        is_input = 1'b1; is_output = 1'b1; out_data = 16'h7777; sw = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            tests_run++;
            if (enable !== 1'b1) begin
                tests_failed++;
                $display("FAIL both_no_stall_%0d: got en=%b required 1", k, enable);
            end
        end
        is_input = 1'b0; is_output = 1'b0;
        cyc(1);
        tests_run++;
        if (display_data !== 16'h1234 || in_data !== 32'h0000_005A) begin
            tests_failed++;
            $display("FAIL both_unchanged: got disp=%h in=%h required disp=1234 in=0000005a",
                     display_data, in_data);
        end
    endtask

    task automatic test_os_request();
        out_data = 16'h0F0F; is_output = 1'b1; user_request = 1'b1;
        cyc(1);
        is_output = 1'b0;
        tests_run++;
        if (os_request !== 1'b0 || enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL os_io_wins: got os=%b en=%b required os=0 en=0", os_request, enable);
        end
        user_request = 1'b0;
        cyc(2);
        user_request = 1'b1;
        cyc(2);
        user_request = 1'b0;
        tests_run++;
        if (os_request !== 1'b0) begin
            tests_failed++;
            $display("FAIL os_hidden_in_wait: got os=%b required 0", os_request);
        end
        continue_debounced = 1'b1;
        cyc(1);
        continue_debounced = 1'b0;
        tests_run++;
        if (os_request !== 1'b0) begin
            tests_failed++;
            $display("FAIL os_hidden_in_commit: got os=%b required 0", os_request);
        end
        slow_clock = 1'b1;
        cyc(2);
        slow_clock = 1'b0;
        cyc(2);
        tests_run++;
        if (os_request !== 1'b1) begin
            tests_failed++;
            $display("FAIL os_presented_in_run: got os=%b required 1", os_request);
        end
        is_os = 1'b1;
        cyc(1);
        tests_run++;
        if (os_request !== 1'b0) begin
            tests_failed++;
            $display("FAIL os_clear_on_is_os: got os=%b required 0", os_request);
        end
        is_os = 1'b0;
        cyc(3);
        tests_run++;
        if (os_request !== 1'b0) begin
            tests_failed++;
            $display("FAIL os_single_request: got os=%b required 0", os_request);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_input();
        test_confirm_held();
        test_output();
        test_both();
        test_os_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_io_stall_sequencer
`default_nettype wire
